stream_mux_rr: RTL and testbench

- Registered, round-robin N:1 stream multiplexer with a valid/ready handshake on every channel.
- It is the sequential successor of the one-hot AND-OR mux. The one-hot select is now generated internally by a fair arbiter, and the selected beat lands in an output register.
- Optional packet mode holds the grant on one channel until that channel's last beat.
- It sits in front of shared resources: response return paths and shared request buses.

---
 rtl/stream_mux_rr.sv | 140 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - registered round-robin N:1 stream multiplexer with optional packet lock
module stream_mux_rr #(
   parameter int N           = 4,
   parameter int W           = 32,
   parameter int PACKET_MODE = 0,
   parameter int IDW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N-1:0]     i_valid,
   input  logic [N*W-1:0]   i_data,
   input  logic [N-1:0]     i_last,
   output logic [N-1:0]     o_ready,
   output logic             o_valid,
   output logic [W-1:0]     o_data,
   output logic             o_last,
   output logic [IDW-1:0]   o_id,
   input  logic             i_ready
);

   localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

   // registered state
   logic             o_valid_q, o_valid_d;
   logic [W-1:0]     o_data_q,  o_data_d;
   logic             o_last_q,  o_last_d;
   logic [IDW-1:0]   o_id_q,    o_id_d;
   logic [IDW-1:0]   ptr_q,     ptr_d;
   logic             lock_q,    lock_d;
   logic [IDW-1:0]   lock_id_q, lock_id_d;

   // combinational datapath
   logic [N-1:0]     grant;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_any;
   logic [W-1:0]     data_sel;
   logic             last_sel;
   logic             en;
   logic [IDW-1:0]   nxt_ptr;

   // Fair arbiter: locked channel only, else first valid channel scanning from ptr upward then wrapping.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      if (lock_q) begin
         for (int j = 0; j < N; j++) begin
            if ((int'(lock_id_q) == j) && i_valid[j]) begin
               grant[j] = 1'b1;
               gnt_idx  = IDW'(j);
            end
         end
      end else begin
         for (int j = 0; j < N; j++) begin
            if ((grant == '0) && i_valid[j] && (j >= int'(ptr_q))) begin
               grant[j] = 1'b1;
               gnt_idx  = IDW'(j);
            end
         end
         for (int j = 0; j < N; j++) begin
            if ((grant == '0) && i_valid[j] && (j < int'(ptr_q))) begin
               grant[j] = 1'b1;
               gnt_idx  = IDW'(j);
            end
         end
      end
   end

   // One-hot AND-OR select of the granted channel's payload and end-of-packet flag.
   always_comb begin
      data_sel = '0;
      last_sel = 1'b0;
      for (int j = 0; j < N; j++) begin
         data_sel = data_sel | ({W{grant[j]}} & i_data[j*W +: W]);
         last_sel = last_sel | (grant[j] & i_last[j]);
      end
   end

   // Load enable, accept strobes and the pointer value following the granted channel.
   always_comb begin
      gnt_any = |grant;
      en      = ~o_valid_q | i_ready;
      o_ready = i_rst_n ? ({N{en}} & grant) : '0;
      nxt_ptr = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDW'(1);
   end

   // Next-state: load a granted beat when the output register is free or draining, else hold.
   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_last_d  = o_last_q;
      o_id_d    = o_id_q;
      ptr_d     = ptr_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (en) begin
         o_valid_d = gnt_any;
         if (gnt_any) begin
            o_data_d = data_sel;
            o_last_d = last_sel;
            o_id_d   = gnt_idx;
            if (PACKET_MODE == 0) begin
               ptr_d = nxt_ptr;
            end else if (last_sel) begin
               ptr_d  = nxt_ptr;
               lock_d = 1'b0;
            end else begin
               lock_d    = 1'b1;
               lock_id_d = gnt_idx;
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_last_q  <= 1'b0;
         o_id_q    <= '0;
         ptr_q     <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_last_q  <= o_last_d;
         o_id_q    <= o_id_d;
         ptr_q     <= ptr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_data  = o_data_q;
   assign o_last  = o_last_q;
   assign o_id    = o_id_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized scoreboard bench for stream_mux_rr in beat and packet modes
`timescale 1ns/1ps
module tb_stream_mux_rr;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int ND = 2;

   localparam int M_IDLE   = 0;
   localparam int M_FAIR   = 1;
   localparam int M_RAND   = 2;
   localparam int M_PKT    = 3;
   localparam int M_SPARSE = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [N-1:0]   s_valid  [ND];
   logic [N*W-1:0] s_data   [ND];
   logic [N-1:0]   s_last   [ND];
   logic [N-1:0]   d_ready  [ND];
   logic           d_valid  [ND];
   logic [W-1:0]   d_data   [ND];
   logic           d_last   [ND];
   logic [1:0]     d_id     [ND];
   logic           dn_ready [ND];

   stream_mux_rr #(.N(N), .W(W), .PACKET_MODE(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid[0]), .i_data(s_data[0]),
      .i_last(s_last[0]), .o_ready(d_ready[0]), .o_valid(d_valid[0]),
      .o_data(d_data[0]), .o_last(d_last[0]), .o_id(d_id[0]), .i_ready(dn_ready[0])
   );

   stream_mux_rr #(.N(N), .W(W), .PACKET_MODE(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid[1]), .i_data(s_data[1]),
      .i_last(s_last[1]), .o_ready(d_ready[1]), .o_valid(d_valid[1]),
      .o_data(d_data[1]), .o_last(d_last[1]), .o_id(d_id[1]), .i_ready(dn_ready[1])
   );

   typedef struct {
      int          id;
      logic [W-1:0] data;
      logic        last;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];

   int checks = 0;
   int errors = 0;

   // reference model state (dut0 arbitrates per beat, dut1 holds grant per packet)
   int m_ptr     [ND];
   bit m_lock    [ND];
   int m_lock_ch [ND];
   bit m_full    [ND];
   int m_g       [ND];
   bit m_en      [ND];
   int acc_ch    [ND];
   int pkt_cnt   [ND];
   int seq       [ND];

   int mode;
   int vprob;
   int rprob;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon(input int d);
      beat_t b;
      int    sz;
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL dut%0d scoreboard: unexpected beat id=%0d data=%0h, expected none", d, d_id[d], d_data[d]);
      end else begin
         if (d == 0) b = q0.pop_front();
         else        b = q1.pop_front();
         check($sformatf("dut%0d o_id", d),   64'(d_id[d]),   64'(b.id));
         check($sformatf("dut%0d o_data", d), 64'(d_data[d]), 64'(b.data));
         check($sformatf("dut%0d o_last", d), 64'(d_last[d]), 64'(b.last));
      end
   endtask

   // output monitors: every downstream transfer is popped and compared
   always @(negedge clk) if (rst_n && d_valid[0] && dn_ready[0]) mon(0);
   always @(negedge clk) if (rst_n && d_valid[1] && dn_ready[1]) mon(1);

   // which channel the fairness rules pick this cycle, or -1
   task automatic model_predict(input int d);
      m_en[d] = !m_full[d] || dn_ready[d];
      m_g[d]  = -1;
      if (m_lock[d]) begin
         if (s_valid[d][m_lock_ch[d]]) m_g[d] = m_lock_ch[d];
      end else begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr[d] + k) % N;
            if (m_g[d] < 0 && s_valid[d][c]) m_g[d] = c;
         end
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_ptr[d] = 0; m_lock[d] = 0; m_lock_ch[d] = 0; m_full[d] = 0; acc_ch[d] = -1;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic gen_sources();
      for (int d = 0; d < ND; d++) begin
         dn_ready[d] = ($urandom_range(99) < rprob);
         for (int c = 0; c < N; c++) begin
            bit            nv;
            logic [W-1:0]  nd;
            bit            nl;
            if (acc_ch[d] == c) s_valid[d][c] = 1'b0;
            if (!s_valid[d][c]) begin
               nv = 0; nd = '0; nl = 1;
               case (mode)
                  M_FAIR: begin nv = 1; nd = 32'h10 + c; nl = 1; end
                  M_RAND: begin nv = ($urandom_range(99) < vprob); nd = $urandom; nl = $urandom_range(1); end
                  M_PKT: begin
                     if (c == 0) begin nv = 1; nd = 32'hA0 + seq[d]; nl = 1; end
                     if (c == 2) begin
                        nv = 1; nd = 32'h200 + pkt_cnt[d]; nl = (pkt_cnt[d] % 3 == 2);
                        pkt_cnt[d]++;
                     end
                  end
                  M_SPARSE: begin
                     if (c == 3 && acc_ch[d] != 3) begin nv = 1; nd = 32'h300 + seq[d]; nl = 1; end
                  end
                  default: nv = 0;
               endcase
               seq[d]++;
               s_valid[d][c]       = nv;
               s_data[d][c*W +: W] = nd;
               s_last[d][c]        = nl;
            end
         end
      end
   endtask

   task automatic step();
      for (int d = 0; d < ND; d++) model_predict(d);
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         logic [N-1:0] er;
         beat_t        b;
         er = '0;
         if (m_en[d] && m_g[d] >= 0) er[m_g[d]] = 1'b1;
         check($sformatf("dut%0d o_ready", d), 64'(d_ready[d]), 64'(er));
         check($sformatf("dut%0d o_valid", d), 64'(d_valid[d]), 64'(m_full[d]));
         if (m_en[d] && m_g[d] >= 0) begin
            b.id   = m_g[d];
            b.data = s_data[d][m_g[d]*W +: W];
            b.last = s_last[d][m_g[d]];
            if (d == 0) q0.push_back(b);
            else        q1.push_back(b);
         end
      end
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
         acc_ch[d] = (m_en[d] && m_g[d] >= 0) ? m_g[d] : -1;
         if (m_en[d]) m_full[d] = (m_g[d] >= 0);
         if (acc_ch[d] >= 0) begin
            if (d == 0 || s_last[d][acc_ch[d]]) begin
               m_ptr[d]  = (acc_ch[d] + 1) % N;
               m_lock[d] = 0;
            end else begin
               m_lock[d]    = 1;
               m_lock_ch[d] = acc_ch[d];
            end
         end
      end
      #1;
      gen_sources();
   endtask

   task automatic run(input int m, input int vp, input int rp, input int cycles);
      mode = m; vprob = vp; rprob = rp;
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         for (int d = 0; d < ND; d++)
            check($sformatf("dut%0d o_ready in reset", d), 64'(d_ready[d]), 64'd0);
         @(posedge clk);
         #1;
         for (int d = 0; d < ND; d++) begin
            check($sformatf("dut%0d reset o_valid", d), 64'(d_valid[d]), 64'd0);
            check($sformatf("dut%0d reset o_id", d),    64'(d_id[d]),    64'd0);
            check($sformatf("dut%0d reset o_data", d),  64'(d_data[d]),  64'd0);
            check($sformatf("dut%0d reset o_last", d),  64'(d_last[d]),  64'd0);
         end
      end
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < ND; d++) begin
         s_valid[d] = '0; s_data[d] = '0; s_last[d] = '0; dn_ready[d] = 1'b1;
         pkt_cnt[d] = 0; seq[d] = 0;
      end
      mode = M_IDLE; vprob = 0; rprob = 100;
      do_reset(2);
      run(M_IDLE, 0, 100, 4);
      run(M_FAIR, 0, 100, 12);
      run(M_FAIR, 0, 0, 3);
      run(M_FAIR, 0, 100, 8);
      do_reset(2);
      run(M_IDLE, 0, 100, 6);
      run(M_SPARSE, 0, 100, 10);
      run(M_IDLE, 0, 100, 4);
      run(M_PKT, 0, 100, 20);
      run(M_PKT, 0, 60, 20);
      run(M_IDLE, 0, 100, 8);
      run(M_RAND, 50, 70, 600);
      run(M_RAND, 90, 100, 200);
      run(M_RAND, 70, 40, 200);
      run(M_FAIR, 0, 0, 1);
      do_reset(1);
      run(M_RAND, 60, 80, 200);
      run(M_IDLE, 0, 100, 10);
      check("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
      check("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
